// File: rtl/ram_vector_ctrl.sv
// Feature-vector RAM sequencer: arbitrates loader writes and engine reads, one vector burst per grant.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise the writer has fixed priority.
module ram_vector_ctrl #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned LENGTH     = 16,
   parameter int unsigned LEN_BITS   = 4,
   parameter int unsigned PT_BITS    = ADDR_WIDTH - LEN_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_req,
   input  logic [PT_BITS-1:0]    wr_pt,
   output logic                  wr_gnt,
   output logic                  wr_take,
   output logic [LEN_BITS-1:0]   wr_feat,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_req,
   input  logic [PT_BITS-1:0]    rd_pt,
   output logic                  rd_gnt,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [LEN_BITS-1:0]   rd_feat,
   output logic                  rd_last,
   output logic                  busy,
   output logic                  ram_cs,
   output logic                  ram_we,
   output logic                  ram_oe,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   inout  wire  [DATA_WIDTH-1:0] ram_data
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_READ  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   localparam logic [LEN_BITS-1:0] CNT_LAST = LEN_BITS'(LENGTH - 1);

   if ((PT_BITS + LEN_BITS != ADDR_WIDTH) || ((1 << LEN_BITS) != LENGTH) ||
       (DEPTH > (1 << PT_BITS))) begin : g_param_err
      $error("ram_vector_ctrl: inconsistent ADDR_WIDTH/LENGTH/LEN_BITS/DEPTH");
   end

   logic [1:0]            state_q, state_d;
   logic [LEN_BITS-1:0]   cnt_q, cnt_d;
   logic [PT_BITS-1:0]    pt_q, pt_d;
   logic                  cap_vld_q, cap_vld_d;
   logic [LEN_BITS-1:0]   cap_feat_q, cap_feat_d;
   logic                  wr_gnt_q, wr_gnt_d;
   logic                  wr_take_q, wr_take_d;
   logic [LEN_BITS-1:0]   wr_feat_q, wr_feat_d;
   logic                  rd_gnt_q, rd_gnt_d;
   logic                  rd_valid_q, rd_valid_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic [LEN_BITS-1:0]   rd_feat_q, rd_feat_d;
   logic                  rd_last_q, rd_last_d;
   logic                  busy_q, busy_d;
   logic                  ram_cs_q, ram_cs_d;
   logic                  ram_we_q, ram_we_d;
   logic                  ram_oe_q, ram_oe_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic                  prefer_w;
`ifdef RAM_ARB_RR_EN
   logic                  last_rd_q, last_rd_d;
`endif

   // Next-state, arbitration and registered-output computation.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pt_d       = pt_q;
      cap_vld_d  = (state_q == S_READ);
      cap_feat_d = cnt_q;
      wr_gnt_d   = 1'b0;
      rd_gnt_d   = 1'b0;
`ifdef RAM_ARB_RR_EN
      last_rd_d  = last_rd_q;
      prefer_w   = last_rd_q;
`else
      prefer_w   = 1'b1;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (wr_req && (!rd_req || prefer_w)) begin
               state_d  = S_WRITE;
               pt_d     = wr_pt;
               wr_gnt_d = 1'b1;
`ifdef RAM_ARB_RR_EN
               last_rd_d = 1'b0;
`endif
            end else if (rd_req) begin
               state_d  = S_READ;
               pt_d     = rd_pt;
               rd_gnt_d = 1'b1;
`ifdef RAM_ARB_RR_EN
               last_rd_d = 1'b1;
`endif
            end
         end
         S_WRITE: begin
            if (cnt_q == CNT_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + LEN_BITS'(1);
            end
         end
         S_READ: begin
            if (cnt_q == CNT_LAST) state_d = S_DRAIN;
            else                   cnt_d   = cnt_q + LEN_BITS'(1);
         end
         S_DRAIN: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // RAM controls reflect the state being entered so they line up with it.
      busy_d     = (state_d != S_IDLE);
      ram_cs_d   = busy_d;
      ram_we_d   = (state_d == S_WRITE);
      ram_oe_d   = (state_d == S_READ) || (state_d == S_DRAIN);
      ram_addr_d = busy_d ? {pt_d, cnt_d} : '0;
      wr_take_d  = ram_we_d;
      wr_feat_d  = ram_we_d ? cnt_d : '0;

      // The bus carries the word addressed one cycle earlier.
      rd_valid_d = cap_vld_q;
      rd_data_d  = cap_vld_q ? ram_data : rd_data_q;
      rd_feat_d  = cap_vld_q ? cap_feat_q : rd_feat_q;
      rd_last_d  = cap_vld_q && (cap_feat_q == CNT_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         pt_q       <= '0;
         cap_vld_q  <= 1'b0;
         cap_feat_q <= '0;
         wr_gnt_q   <= 1'b0;
         wr_take_q  <= 1'b0;
         wr_feat_q  <= '0;
         rd_gnt_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_feat_q  <= '0;
         rd_last_q  <= 1'b0;
         busy_q     <= 1'b0;
         ram_cs_q   <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_oe_q   <= 1'b0;
         ram_addr_q <= '0;
`ifdef RAM_ARB_RR_EN
         last_rd_q  <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pt_q       <= pt_d;
         cap_vld_q  <= cap_vld_d;
         cap_feat_q <= cap_feat_d;
         wr_gnt_q   <= wr_gnt_d;
         wr_take_q  <= wr_take_d;
         wr_feat_q  <= wr_feat_d;
         rd_gnt_q   <= rd_gnt_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_feat_q  <= rd_feat_d;
         rd_last_q  <= rd_last_d;
         busy_q     <= busy_d;
         ram_cs_q   <= ram_cs_d;
         ram_we_q   <= ram_we_d;
         ram_oe_q   <= ram_oe_d;
         ram_addr_q <= ram_addr_d;
`ifdef RAM_ARB_RR_EN
         last_rd_q  <= last_rd_d;
`endif
      end
   end

   assign wr_gnt   = wr_gnt_q;
   assign wr_take  = wr_take_q;
   assign wr_feat  = wr_feat_q;
   assign rd_gnt   = rd_gnt_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign rd_feat  = rd_feat_q;
   assign rd_last  = rd_last_q;
   assign busy     = busy_q;
   assign ram_cs   = ram_cs_q;
   assign ram_we   = ram_we_q;
   assign ram_oe   = ram_oe_q;
   assign ram_addr = ram_addr_q;

   // Only drive the bus while writing; the RAM owns it otherwise.
   assign ram_data = ram_we_q ? wr_data : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_vector_ctrl.sv
// Scoreboard bench for ram_vector_ctrl with a synchronous-read RAM model on the shared bus.
module tb_ram_vector_ctrl;
   localparam int unsigned AW  = 14;
   localparam int unsigned DW  = 32;
   localparam int unsigned LEN = 16;

   typedef struct packed { logic [13:0] addr; logic [31:0] data; } wexp_t;
   typedef struct packed { logic [3:0] feat; logic [31:0] data; logic last; } rexp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_req, rd_req;
   logic [9:0]    wr_pt, rd_pt;
   logic          wr_gnt, wr_take, rd_gnt, rd_valid, rd_last, busy;
   logic [3:0]    wr_feat, rd_feat;
   logic [31:0]   wr_data, rd_data, wr_base;
   logic          ram_cs, ram_we, ram_oe;
   logic [13:0]   ram_addr;
   wire  [31:0]   ram_data;

   logic [31:0]   mem [0:16383];
   logic [31:0]   rdata_q;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wg_cyc = 0;
   int rg_cyc = 0;

   wexp_t wq[$];
   rexp_t rq[$];
   bit    gq[$];

   ram_vector_ctrl dut (
      .clk(clk), .rst(rst),
      .wr_req(wr_req), .wr_pt(wr_pt), .wr_gnt(wr_gnt), .wr_take(wr_take),
      .wr_feat(wr_feat), .wr_data(wr_data),
      .rd_req(rd_req), .rd_pt(rd_pt), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
      .rd_data(rd_data), .rd_feat(rd_feat), .rd_last(rd_last),
      .busy(busy), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
      .ram_addr(ram_addr), .ram_data(ram_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign wr_data = wr_base + 32'(wr_feat);

   // Synchronous RAM: word for the address of cycle t is on the bus in cycle t+1.
   always @(posedge clk) begin
      if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
      if (ram_cs && ram_oe && !ram_we) rdata_q <= mem[ram_addr];
   end
   assign ram_data = (ram_cs && ram_oe && !ram_we) ? rdata_q : 32'hzzzz_zzzz;

   function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endfunction

   function automatic void fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endfunction

   function automatic logic [63:0] all_outs();
      return 64'({wr_gnt, wr_take, wr_feat, rd_gnt, rd_valid, rd_data, rd_feat,
                  rd_last, busy, ram_cs, ram_we, ram_oe, ram_addr});
   endfunction

   // Monitor: grants first so burst timing references the current cycle.
   always @(negedge clk) begin
      if (!rst) begin
         chk("we_oe_excl", 64'(ram_we & ram_oe), 64'd0);
         if (wr_gnt || rd_gnt) begin
            chk("gnt_onehot", 64'(wr_gnt & rd_gnt), 64'd0);
            if (gq.size() == 0) fail_now("gnt_unexpected");
            else chk("gnt_side", 64'(rd_gnt), 64'(gq.pop_front()));
            if (wr_gnt) wg_cyc = cyc;
            if (rd_gnt) rg_cyc = cyc;
         end
         if (ram_we) begin
            if (wq.size() == 0) fail_now("write_unexpected");
            else begin
               wexp_t w;
               w = wq.pop_front();
               chk("wr_addr", 64'(ram_addr), 64'(w.addr));
               chk("wr_bus_data", 64'(ram_data), 64'(w.data));
               chk("wr_take", 64'(wr_take), 64'd1);
               chk("wr_feat", 64'(wr_feat), 64'(w.addr[3:0]));
               chk("wr_timing", 64'(cyc - wg_cyc), 64'(w.addr[3:0]));
            end
         end else begin
            chk("wr_take_idle", 64'(wr_take), 64'd0);
         end
         if (rd_valid) begin
            if (rq.size() == 0) fail_now("rd_valid_unexpected");
            else begin
               rexp_t r;
               r = rq.pop_front();
               chk("rd_feat", 64'(rd_feat), 64'(r.feat));
               chk("rd_data", 64'(rd_data), 64'(r.data));
               chk("rd_last", 64'(rd_last), 64'(r.last));
               chk("rd_timing", 64'(cyc - rg_cyc), 64'(r.feat) + 64'd2);
            end
         end else begin
            chk("rd_last_idle", 64'(rd_last), 64'd0);
         end
      end
   end

   task automatic wait_gnt(input bit is_rd);
      bit got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (is_rd ? rd_gnt : wr_gnt) got = 1'b1;
      end
      if (!got) fail_now(is_rd ? "rd_gnt_timeout" : "wr_gnt_timeout");
   endtask

   task automatic wait_idle();
      bit got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (!busy) got = 1'b1;
      end
      if (!got) fail_now("idle_timeout");
   endtask

   task automatic push_write(input logic [9:0] p, input logic [31:0] b);
      for (int k = 0; k < LEN; k++) wq.push_back('{addr: {p, 4'(k)}, data: b + 32'(k)});
   endtask

   task automatic push_read(input logic [31:0] b);
      for (int k = 0; k < LEN; k++)
         rq.push_back('{feat: 4'(k), data: b + 32'(k), last: (k == LEN - 1)});
   endtask

   task automatic do_write(input logic [9:0] p, input logic [31:0] b);
      wr_pt = p;
      wr_base = b;
      gq.push_back(1'b0);
      push_write(p, b);
      wr_req = 1'b1;
      wait_gnt(1'b0);
      wr_req = 1'b0;
      wait_idle();
   endtask

   task automatic do_read(input logic [9:0] p, input logic [31:0] b);
      rd_pt = p;
      gq.push_back(1'b1);
      push_read(b);
      rd_req = 1'b1;
      wait_gnt(1'b1);
      rd_req = 1'b0;
      wait_idle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog_expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int t1;
      int t2;
      rst = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
      wr_pt = '0; rd_pt = '0; wr_base = '0;

      // Reset held two cycles with both requests up.
      repeat (2) begin
         @(negedge clk);
         chk("reset_outs", all_outs(), 64'd0);
      end
      wr_req = 1'b0; rd_req = 1'b0; rst = 1'b0;
      @(negedge clk);
      chk("post_reset_outs", all_outs(), 64'd0);

      // Write then read point 5.
      do_write(10'd5, 32'hA000_0000);
      do_read(10'd5, 32'hA000_0000);

      // Address boundaries.
      do_write(10'd1023, 32'hB000_0000);
      do_read(10'd1023, 32'hB000_0000);
      do_write(10'd0, 32'hC000_0000);
      do_read(10'd0, 32'hC000_0000);

      // Contention: both requests held for three grants.
      wr_pt = 10'd7; wr_base = 32'hF000_0000; rd_pt = 10'd5;
`ifdef RAM_ARB_RR_EN
      gq.push_back(1'b0); gq.push_back(1'b1); gq.push_back(1'b0);
      push_write(10'd7, 32'hF000_0000);
      push_read(32'hA000_0000);
      push_write(10'd7, 32'hF000_0000);
`else
      gq.push_back(1'b0); gq.push_back(1'b0); gq.push_back(1'b0);
      push_write(10'd7, 32'hF000_0000);
      push_write(10'd7, 32'hF000_0000);
      push_write(10'd7, 32'hF000_0000);
`endif
      wr_req = 1'b1; rd_req = 1'b1;
      n = 0;
      for (int i = 0; i < 200 && n < 3; i++) begin
         @(negedge clk);
         if (wr_gnt || rd_gnt) n++;
      end
      wr_req = 1'b0; rd_req = 1'b0;
      if (n < 3) fail_now("contention_timeout");
      wait_idle();

      // Reset after five read beats.
      rd_pt = 10'd5;
      gq.push_back(1'b1);
      push_read(32'hA000_0000);
      rd_req = 1'b1;
      wait_gnt(1'b1);
      rd_req = 1'b0;
      n = 0;
      for (int i = 0; i < 40 && n < 5; i++) begin
         @(negedge clk);
         if (rd_valid) n++;
      end
      if (n < 5) fail_now("midreset_beats_timeout");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rq.delete();
      chk("midreset_rd_valid", 64'(rd_valid), 64'd0);
      chk("midreset_ram_cs", 64'(ram_cs), 64'd0);
      chk("midreset_busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("midreset_rd_valid_after", 64'(rd_valid), 64'd0);
      do_write(10'd2, 32'hD000_0000);
      do_read(10'd2, 32'hD000_0000);

      // Back-to-back reads with rd_req held.
      do_write(10'd1, 32'hE000_0000);
      gq.push_back(1'b1); gq.push_back(1'b1);
      push_read(32'hE000_0000);
      push_read(32'hD000_0000);
      rd_pt = 10'd1;
      rd_req = 1'b1;
      wait_gnt(1'b1);
      t1 = cyc;
      rd_pt = 10'd2;
      wait_gnt(1'b1);
      t2 = cyc;
      rd_req = 1'b0;
      chk("read_period", 64'(t2 - t1), 64'd18);
      wait_idle();

      repeat (3) @(negedge clk);
      chk("wq_drained", 64'(wq.size()), 64'd0);
      chk("rq_drained", 64'(rq.size()), 64'd0);
      chk("gq_drained", 64'(gq.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ram_vector_ctrl.md
# ram_vector_ctrl

Sequencer and arbiter for the feature-vector RAM. It shares the RAM between two requesters: a loader that writes data-point vectors and a compute engine that reads them. Each grant moves one complete vector of LENGTH feature words as a burst, using one RAM access per cycle. The block owns every RAM control pin and the bidirectional data bus, so the RAM never sees two masters.

## Interface
Parameters:
- ADDR_WIDTH, 14, RAM word-address width; address layout is {point, feature}
- DATA_WIDTH, 32, feature word width
- DEPTH, 1024, number of data points
- LENGTH, 16, number of features per point
- LEN_BITS, 4, feature-index width (log2 LENGTH)
- PT_BITS, ADDR_WIDTH-LEN_BITS (10), point-index width

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset
- wr_req  in  1  loader requests a vector write; hold until wr_gnt
- wr_pt  in  PT_BITS  target point; sampled on the grant edge
- wr_gnt  out  1  one-cycle pulse in the first WRITE cycle
- wr_take  out  1  high on each cycle the current wr_data word is consumed
- wr_feat  out  LEN_BITS  feature index being consumed
- wr_data  in  DATA_WIDTH  loader word for wr_feat, combinational in the same cycle
- rd_req  in  1  engine requests a vector read; hold until rd_gnt
- rd_pt  in  PT_BITS  source point; sampled on the grant edge
- rd_gnt  out  1  one-cycle pulse in the first READ cycle
- rd_valid  out  1  rd_data/rd_feat valid this cycle
- rd_data  out  DATA_WIDTH  registered feature word
- rd_feat  out  LEN_BITS  feature index of rd_data
- rd_last  out  1  with rd_valid, marks feature LENGTH-1
- busy  out  1  state is not IDLE
- ram_cs, ram_we, ram_oe  out  1 each  RAM controls
- ram_addr  out  ADDR_WIDTH  {point, feature}
- ram_data  inout  DATA_WIDTH  RAM bus; driven only in WRITE, otherwise high-Z

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: pick a requester by the arbitration rule, latch its point, clear the feature counter cnt, then go to WRITE or READ.
- WRITE, LENGTH cycles:
  - outputs: ram_cs=1, ram_we=1, ram_oe=0, ram_addr={pt,cnt}; wr_take=1, wr_feat=cnt.
  - ram_data is driven with wr_data.
  - cnt increments each cycle; at cnt==LENGTH-1 go to IDLE.
- READ, LENGTH cycles:
  - outputs: ram_cs=1, ram_we=0, ram_oe=1, ram_addr={pt,cnt}; ram_data is high-Z.
  - at cnt==LENGTH-1 go to DRAIN.
- DRAIN, 1 cycle: ram_cs=1, ram_oe=1, ram_we=0, address held, so the last RAM word appears on the bus.
- Capture: each cycle where the RAM bus carries the word for feature k, register it. rd_data=word, rd_feat=k and rd_valid=1 in the following cycle; rd_last when k==LENGTH-1.
- Bus contention is impossible: ram_data is driven only while ram_we=1, and the RAM drives only while ram_we=0.
- Arbitration: default is fixed priority, writer over reader (see Configuration). Requests are sampled only in IDLE; a request raised mid-burst waits.
- A requester still asserting req after its burst is served again (re-grant).
- Widths: cnt is LEN_BITS wide. No point wraps: pt is taken verbatim and cnt never exceeds LENGTH-1.

## Timing
- Grant: request sampled in IDLE at edge E. State, gnt pulse and the first RAM access all start in the cycle after E (cycle G).
- Write: words consumed in cycles G..G+LENGTH-1; IDLE at G+LENGTH. Minimum period between write bursts is LENGTH+1 cycles.
- Read: address k is issued in cycle G+k and rd_valid for feature k is high in cycle G+k+2.
  - rd_last is high in G+LENGTH+1; IDLE at G+LENGTH+1.
  - Minimum period between read bursts is LENGTH+2 cycles.
- Reset mid-burst: in the cycle after the reset edge, state is IDLE and every output is 0 or high-Z. A partly written vector stays in RAM; no further rd_valid is produced.
- Reset values: state=IDLE, cnt=0, every output=0 (including rd_data=0 and ram_addr=0), ram_data=Z, round-robin pointer = "reader last served".

## Configuration
- RAM_ARB_RR_EN defined: round-robin arbitration.
  - When both requests are high in IDLE, grant the side not served last.
  - The pointer updates on every grant.
- RAM_ARB_RR_EN undefined: fixed priority; the writer always wins ties and can starve the reader.
- Single requests are granted identically in both builds.

## Test plan
- Reset: assert rst for 2 cycles with both requests high → during and one cycle after reset, all outputs 0, ram_data=Z, busy=0.
- Write then read: write point 5 with word k = 0xA000_0000+k → RAM addresses 0x0050..0x005F written, wr_take high for exactly 16 cycles. Then read point 5 → rd_valid in cycles G+2..G+17, rd_data=0xA000_0000+rd_feat, rd_last only with feature 15.
- Boundaries: write and read point 1023, then point 0 → ram_addr covers 0x3FF0..0x3FFF and 0x0000..0x000F, and data reads back intact.
- Contention: hold both requests for three grants.
  - With RAM_ARB_RR_EN: grant order W, R, W.
  - Without it: W, W, W with rd_gnt never asserted.
- Mid-burst reset: pulse rst after 5 rd_valid beats of a read → next cycle rd_valid=0, ram_cs=0, state IDLE. A following write to point 2 then completes normally.
- Back-to-back reads: read point 1 with rd_req held, then point 2 → exactly 32 rd_valid beats, two rd_last pulses 18 cycles apart, and ram_data never driven by the controller.
